// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared types and constants for the load/store unit
package core_lsu_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ERR} state_t;
   typedef enum logic [1:0] {W_B = 2'd0, W_H = 2'd1, W_W = 2'd2} width_t;
   typedef struct packed {
      logic   uns;
      width_t wid;
   } op_t;
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;
endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: byte-lane steering for stores and lane extraction/extension for loads
module core_lsu_align
   import core_lsu_pkg::*;
(
   input  op_t         op,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b         = rdata[{off, 3'b000} +: 8];
      h         = off[1] ? rdata[31:16] : rdata[15:0];
      be        = op.wid == W_B ? BE_B << off : op.wid == W_H ? (off[1] ? BE_H << 2 : BE_H) : BE_W;
      wdata_rep = op.wid == W_B ? {4{wdata[7:0]}} : op.wid == W_H ? {2{wdata[15:0]}} : wdata;
      ld_data   = op.wid == W_B ? {{24{~op.uns & b[7]}}, b} :
                  op.wid == W_H ? {{16{~op.uns & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/core_lsu.sv
// core_lsu: blocking load/store unit with req/ack bus, misalignment check and bus timeout
module core_lsu
   import core_lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   input  logic        i_lb,
   input  logic        i_lh,
   input  logic        i_lw,
   input  logic        i_lbu,
   input  logic        i_lhu,
   input  logic        i_sb,
   input  logic        i_sh,
   input  logic        i_sw,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_rd,
   output logic        o_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_rd,
   output logic        o_done,
   output logic        o_misaligned,
   output logic        o_bus_err
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   state_t        state;
   op_t           op_q, dec_op;
   logic          we_q, dec_we, dec_any, dec_mis;
   logic [31:0]   addr_q, wdata_q;
   logic [4:0]    rd_q;
   logic [CW-1:0] cnt;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, ld_data;
   always_comb begin
      dec_any    = |{i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw};
      dec_we     = ~(i_lb | i_lh | i_lw | i_lbu | i_lhu);
      dec_op.uns = ~(i_lb | i_lh | i_lw) & (i_lbu | i_lhu);
      dec_op.wid = i_lb ? W_B : i_lh ? W_H : i_lw ? W_W : i_lbu ? W_B :
                   i_lhu ? W_H : i_sb ? W_B : i_sh ? W_H : W_W;
      dec_mis    = dec_op.wid == W_H ? i_addr[0] : dec_op.wid == W_W ? |i_addr[1:0] : 1'b0;
   end
   core_lsu_align u_align (
      .op       (op_q),
      .off      (addr_q[1:0]),
      .wdata    (wdata_q),
      .rdata    (mem_rdata),
      .be       (be),
      .wdata_rep(wdata_rep),
      .ld_data  (ld_data)
   );
   assign o_ready   = state == ST_IDLE;
   assign mem_req   = state == ST_REQ;
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_be    = mem_req ? be : '0;
   assign mem_wdata = mem_req ? wdata_rep : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op_q         <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
         cnt          <= '0;
         o_wb_valid   <= 1'b0;
         o_wb_data    <= '0;
         o_wb_rd      <= '0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
      end else begin
         o_wb_valid   <= 1'b0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
         case (state)
            ST_IDLE: if (i_valid && dec_any) begin
               op_q         <= dec_op;
               we_q         <= dec_we;
               addr_q       <= i_addr;
               wdata_q      <= i_wdata;
               rd_q         <= i_rd;
               cnt          <= '0;
               o_misaligned <= dec_mis;
               state        <= dec_mis ? ST_ERR : ST_REQ;
            end
            ST_REQ: if (mem_ack) begin
               state      <= ST_RESP;
               o_wb_valid <= ~we_q;
               o_done     <= we_q;
               if (!we_q) begin
                  o_wb_data <= ld_data;
                  o_wb_rd   <= rd_q;
               end
            end else if (TIMEOUT != 0 && cnt == LAST) begin
               state     <= ST_ERR;
               o_bus_err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: vector table, randomized ops against a lane-arithmetic model, timeout and reset sequences
module tb_core_lsu;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        i_valid = 1'b0, i_lb = 1'b0, i_lh = 1'b0, i_lw = 1'b0, i_lbu = 1'b0;
   logic        i_lhu = 1'b0, i_sb = 1'b0, i_sh = 1'b0, i_sw = 1'b0;
   logic [31:0] i_addr = '0, i_wdata = '0, mem_rdata = '0;
   logic [4:0]  i_rd = '0;
   logic        mem_ack = 1'b0;
   logic        o_ready, mem_req, mem_we, o_wb_valid, o_done, o_misaligned, o_bus_err;
   logic [31:0] mem_addr, mem_wdata, o_wb_data;
   logic [3:0]  mem_be;
   logic [4:0]  o_wb_rd;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] last_wb = '0;

   core_lsu #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
      .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu), .i_lhu(i_lhu),
      .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .o_ready(o_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
      .o_done(o_done), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  fl;
      logic [31:0] addr, wdata, rdata;
      logic [4:0]  rd;
      int          dly;
      logic        mis, st;
      logic [3:0]  be;
      logic [31:0] wd, wb;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_flags(input logic [7:0] fl);
      {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb} = fl;
   endtask

   // flag bit k: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw; lowest set bit wins
   function automatic void model(input logic [7:0] fl, input logic [31:0] addr, wdata, rdata,
                                 output logic st, mis, output logic [3:0] be,
                                 output logic [31:0] wd, wb);
      int sz[8] = '{1, 2, 4, 1, 2, 1, 2, 4};
      int k = 0, off;
      logic [31:0] mask, v;
      while (!fl[k]) k++;
      off  = int'(addr % 4);
      st   = k >= 5;
      mis  = (addr % sz[k]) != 0;
      be   = 4'(((1 << sz[k]) - 1) << off);
      wd   = sz[k] == 1 ? wdata[7:0] * 32'h0101_0101 : sz[k] == 2 ? wdata[15:0] * 32'h0001_0001 : wdata;
      mask = sz[k] == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz[k])) - 1;
      v    = (rdata >> (8 * off)) & mask;
      if (k < 2 && (v & ~(mask >> 1) & mask) != 0) v = v | ~mask;
      wb   = v;
   endfunction

   task automatic run_op(input logic [7:0] fl, input logic [31:0] addr, wdata, rdata,
                         input logic [4:0] rd, input int dly, input logic mis, st,
                         input logic [3:0] be, input logic [31:0] wd, wb);
      chk("ready_before_op", o_ready, 1);
      set_flags(fl);
      i_valid = 1; i_addr = addr; i_wdata = wdata; i_rd = rd;
      @(negedge clk);
      i_valid = 0; set_flags(8'h00); i_addr = $urandom; i_wdata = $urandom; i_rd = 5'($urandom);
      if (mis) begin
         chk("misaligned_pulse", o_misaligned, 1);
         chk("misaligned_no_req", mem_req, 0);
         chk("misaligned_not_ready", o_ready, 0);
         @(negedge clk);
         chk("misaligned_clear", o_misaligned, 0);
         chk("misaligned_ready", o_ready, 1);
      end else begin
         chk("req_high", mem_req, 1);
         chk("req_we", mem_we, st);
         chk("req_addr", mem_addr, addr & ~32'h3);
         chk("req_be", mem_be, be);
         if (st) chk("req_wdata", mem_wdata, wd);
         repeat (dly) begin
            @(negedge clk);
            chk("req_held", mem_req, 1);
         end
         mem_ack = 1; mem_rdata = rdata;
         @(negedge clk);
         mem_ack = 0; mem_rdata = $urandom;
         chk("req_dropped", mem_req, 0);
         chk("wb_valid", o_wb_valid, !st);
         chk("done", o_done, st);
         chk("resp_not_ready", o_ready, 0);
         if (!st) begin
            chk("wb_data", o_wb_data, wb);
            chk("wb_rd", o_wb_rd, rd);
            last_wb = wb;
         end else chk("wb_data_hold", o_wb_data, last_wb);
         @(negedge clk);
         chk("ready_after", o_ready, 1);
         chk("pulses_clear", {o_wb_valid, o_done}, 0);
      end
   endtask

   initial begin
      logic [7:0]  fl;
      logic [31:0] a, wd_in, rd_in, e_wd, e_wb;
      logic [3:0]  e_be;
      logic        e_st, e_mis;
      int          n;
      tbl[0]  = '{8'h01, 32'h0000_1003, 32'h0,         32'h80FF_1234, 5'd1,  0, 1'b0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
      tbl[1]  = '{8'h10, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 5'd2,  1, 1'b0, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF};
      tbl[2]  = '{8'h02, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 5'd3,  0, 1'b0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_BEEF};
      tbl[3]  = '{8'h20, 32'h0000_0101, 32'h1234_56A5, 32'h0,         5'd4,  3, 1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0};
      tbl[4]  = '{8'h04, 32'h0000_0006, 32'h0,         32'h0,         5'd5,  0, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};
      tbl[5]  = '{8'h40, 32'h0000_0003, 32'h0,         32'h0,         5'd6,  0, 1'b1, 1'b1, 4'b0000, 32'h0,         32'h0};
      tbl[6]  = '{8'h80, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         5'd7,  2, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      tbl[7]  = '{8'h08, 32'h0000_1001, 32'h0,         32'h0000_8100, 5'd8,  0, 1'b0, 1'b0, 4'b0010, 32'h0,         32'h0000_0081};
      tbl[8]  = '{8'h81, 32'h0000_0202, 32'h0,         32'h00FF_0000, 5'd9,  1, 1'b0, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FFFF};
      tbl[9]  = '{8'h40, 32'h0000_0022, 32'h0000_BEEF, 32'h0,         5'd10, 0, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      tbl[10] = '{8'h84, 32'h0000_0010, 32'h0,         32'h1234_5678, 5'd11, 2, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
      tbl[11] = '{8'h02, 32'h0000_0005, 32'h0,         32'h0,         5'd12, 0, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0};

      repeat (2) @(negedge clk);
      chk("rst_ready", o_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pulses", {o_wb_valid, o_done, o_misaligned, o_bus_err}, 0);
      chk("rst_wb", o_wb_data, 0);
      rst_n = 1;
      @(negedge clk);

      foreach (tbl[i])
         run_op(tbl[i].fl, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].rd, tbl[i].dly,
                tbl[i].mis, tbl[i].st, tbl[i].be, tbl[i].wd, tbl[i].wb);

      i_valid = 1; set_flags(8'h00); i_addr = 32'h40;
      @(negedge clk);
      i_valid = 0;
      chk("noflag_ready", o_ready, 1);
      chk("noflag_no_req", mem_req, 0);

      for (int i = 0; i < 80; i++) begin
         fl    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'(1 << $urandom_range(0, 7));
         a     = $urandom;
         wd_in = $urandom;
         rd_in = $urandom;
         model(fl, a, wd_in, rd_in, e_st, e_mis, e_be, e_wd, e_wb);
         run_op(fl, a, wd_in, rd_in, 5'($urandom), $urandom_range(0, 4), e_mis, e_st, e_be, e_wd, e_wb);
      end

      set_flags(8'h04); i_valid = 1; i_addr = 32'h40;
      @(negedge clk);
      i_valid = 0; set_flags(8'h00);
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_req_cycles", n, 16);
      chk("timeout_bus_err", o_bus_err, 1);
      chk("timeout_not_ready", o_ready, 0);
      @(negedge clk);
      chk("timeout_err_clear", o_bus_err, 0);
      chk("timeout_ready", o_ready, 1);
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 0;
      chk("late_ack_no_req", mem_req, 0);
      chk("late_ack_no_pulse", {o_wb_valid, o_done, o_bus_err}, 0);
      chk("late_ack_ready", o_ready, 1);

      set_flags(8'h04); i_valid = 1; i_addr = 32'h80;
      @(negedge clk);
      i_valid = 0; set_flags(8'h00);
      chk("pre_reset_req", mem_req, 1);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_reset_req", mem_req, 0);
      chk("async_reset_ready", o_ready, 1);
      last_wb = '0;
      @(negedge clk);
      rst_n = 1; mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      chk("post_reset_no_req", mem_req, 0);
      chk("post_reset_no_pulse", {o_wb_valid, o_done}, 0);
      run_op(8'h04, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5'd21, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D);
      run_op(8'h80, 32'h0000_0104, 32'h0102_0304, 32'h0, 5'd22, 1, 1'b0, 1'b1, 4'b1111, 32'h0102_0304, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the Adelie core, directly downstream of `core_alu`. It takes the ALU-computed effective address, the store data (RS2) and a one-hot load/store flag. It runs a single blocking transaction on the data-memory bus with req/ack handshake, byte-lane steering and sign/zero extension. Load results are returned to the register write-back path, and misalignment and bus timeout are reported as one-cycle error pulses.

## Interface
- `TIMEOUT`, default 16: cycles `mem_req` may stay unacknowledged before abort; 0 disables the timeout.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  execute stage presents a memory op.
- `i_lb`, `i_lh`, `i_lw`, `i_lbu`, `i_lhu`, `i_sb`, `i_sh`, `i_sw`  in  1 each  one-hot op flags from decode.
- `i_addr`  in  32  effective address (ALU RESULT).
- `i_wdata`  in  32  store data (RS2).
- `i_rd`  in  5  destination register for loads.
- `o_ready`  out  1  unit idle; request accepted this cycle if `i_valid`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables, bit n = byte lane n.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion; one-cycle pulse.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `o_wb_valid`  out  1  one-cycle load result pulse.
- `o_wb_data`  out  32  extended load data.
- `o_wb_rd`  out  5  destination register.
- `o_done`  out  1  one-cycle pulse when a store completes.
- `o_misaligned`  out  1  one-cycle misalignment pulse.
- `o_bus_err`  out  1  one-cycle timeout pulse.

## Operation
- States:
  - IDLE: `o_ready=1`.
  - REQ: `mem_req=1`.
  - RESP: result pulses.
  - ERR: error pulse.
- IDLE → REQ: `i_valid` high with at least one flag set and an aligned address. Latch op, `i_addr`, `i_wdata` and `i_rd`.
- IDLE → ERR: `i_valid` with a misaligned address. LH/LHU/SH are misaligned when addr[0]≠0; LW/SW when addr[1:0]≠0. No bus request is issued.
- `i_valid` with no flag set: ignored; stay in IDLE.
- Multiple flags set: priority LB>LH>LW>LBU>LHU>SB>SH>SW.
- REQ → RESP on `mem_ack`; `mem_rdata` is latched in that cycle.
- REQ → ERR after `TIMEOUT` REQ cycles without ack.
- RESP → IDLE and ERR → IDLE unconditionally.
- ERR drives `o_misaligned` or `o_bus_err` according to cause.
- Byte lanes are little-endian, with off = addr[1:0]:
  - Byte ops: `mem_be = 1<<off`; store data `{4{wdata[7:0]}}`.
  - Half ops: `mem_be` = 0011 (off=0) or 1100 (off=2); store data `{2{wdata[15:0]}}`.
  - Word ops: `mem_be` = 1111; store data `wdata`.
  - `mem_be` is driven for loads too; `mem_we` = 0 for loads.
- Load data is extracted from lane `off`:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `mem_addr = {addr[31:2], 2'b00}`.
- `mem_wdata` and `mem_be` are don't-care when `mem_req` = 0; they are driven 0.
- A `mem_ack` arriving outside REQ is ignored.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational input→output paths except `o_ready`, which is state-only.
- Request accepted at edge T:
  - `mem_req` high from T+1 until the ack cycle A inclusive.
  - Ack in the first REQ cycle gives A = T+1.
  - `o_wb_valid`/`o_done` in cycle A+1; `o_ready` high again in A+2.
- Misaligned request accepted at T: `o_misaligned` in T+1; `o_ready` in T+2.
- Timeout:
  - REQ is entered at T+1, so the REQ counter counts from T+1.
  - `mem_req` is high for exactly `TIMEOUT` cycles.
  - `o_bus_err` is high the following cycle.
- Reset values (asynchronous): state IDLE, `o_ready=1`, every other output 0, timeout counter 0.
- Reset asserted mid-transaction drops `mem_req` immediately. A late ack after reset is ignored.
- `o_wb_data`/`o_wb_rd` hold their last value outside `o_wb_valid`.

## Structure
- `core_lsu_pkg`:
  - state enum (IDLE/REQ/RESP/ERR).
  - 3-bit internal op encoding with a width field (B/H/W) and an unsigned bit.
  - byte-enable constants.
- One combinational sub-module, `core_lsu_align`: op + offset + wdata/rdata → be, replicated wdata, extended load data. `core_lsu` holds the FSM, timeout counter and latches.

## Test plan
- LB, addr 0x0000_1003, `mem_rdata` 0x80FF_1234, ack in first REQ cycle → `mem_addr` 0x0000_1000, be 1000, `o_wb_data` 0xFFFF_FF80, `o_wb_valid` in cycle T+2.
- LHU, addr 0x0000_2002, `mem_rdata` 0xBEEF_0000 → be 1100, `o_wb_data` 0x0000_BEEF; LH on the same data → 0xFFFF_BEEF.
- SB, addr 0x0000_0101, wdata 0x1234_56A5, ack after 3 cycles → `mem_we`=1, be 0010, `mem_wdata` 0xA5A5_A5A5, `o_done` one cycle after ack, no `o_wb_valid`.
- LW, addr 0x0000_0006 → no `mem_req`, `o_misaligned` at T+1. SH, addr 0x0000_0003 → same. SW, addr 0x0000_0004 → normal request, be 1111.
- TIMEOUT=16, LW with `mem_ack` held 0 → `mem_req` high exactly 16 cycles, then `o_bus_err` pulse, then `o_ready`=1. A late ack is ignored.
- `rst_n` pulled low mid-REQ → `mem_req` drops asynchronously, `o_ready`=1 after release. A back-to-back LW/SW pair then completes with correct `wb`/`done` sequencing.
